// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
package clk_gen_pkg;

  localparam logic MODE_STROBE = 1'b0;
  localparam logic MODE_TGL    = 1'b1;

  // Phase increment for f_out from f_clk with an acc_w-bit accumulator (floor).
  function automatic logic [31:0] inc_for(input longint unsigned f_out,
                                          input longint unsigned f_clk,
                                          input int unsigned     acc_w);
    longint unsigned scaled;
    scaled = f_out << acc_w;
    return 32'(scaled / f_clk);
  endfunction

endpackage

// File: rtl/frac_acc_ch.sv
// One fractional clock-enable channel: phase accumulator, live config and
// registered ce/tgl outputs, with a commit port for glitch-free updates.
module frac_acc_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned      ACC_W   = 16,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_i,
  input  logic             commit,
  input  logic [ACC_W-1:0] commit_inc,
  input  logic             commit_mode,
  input  logic             commit_en,
  output logic             carry_c,
  output logic             en,
  output logic             ce,
  output logic             tgl
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic             mode;
  logic [ACC_W:0]   sum_c;

  // Carry out of the ACC_W+1 bit sum marks the end of one output period.
  always_comb begin
    sum_c   = {1'b0, acc} + {1'b0, inc};
    carry_c = en & sum_c[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      inc  <= RST_INC;
      mode <= MODE_STROBE;
      en   <= 1'b0;
      ce   <= 1'b0;
      tgl  <= 1'b0;
    end else if (sync_i) begin
      // Phase alignment wins over any carry this cycle.
      acc <= '0;
      ce  <= 1'b0;
      tgl <= 1'b0;
      if (commit) begin
        inc  <= commit_inc;
        mode <= commit_mode;
        en   <= commit_en;
      end
    end else begin
      ce  <= carry_c;
      acc <= en ? sum_c[ACC_W-1:0] : '0;
      tgl <= (en && (mode == MODE_TGL)) ? (tgl ^ carry_c) : 1'b0;
      if (commit) begin
        inc  <= commit_inc;
        mode <= commit_mode;
        en   <= commit_en;
        if (!en || !commit_en) begin
          acc <= '0;
        end
        if (!commit_en || (commit_mode != mode)) begin
          tgl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/frac_clk_en_gen.sv
// Multi-channel fractional clock-enable generator: single-slot config
// handshake, commit scheduling with stall watchdog, and sync fan-out.
module frac_clk_en_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned      NUM_CH  = 4,
  parameter int unsigned      ACC_W   = 16,
  parameter int unsigned      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] tgl_o,
  output logic              busy_o
);

  localparam logic [ACC_W:0] WDOG_LAST = {1'b0, {ACC_W{1'b1}}};

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [ACC_W-1:0]  pend_inc;
  logic              pend_mode;
  logic              pend_en;
  logic [ACC_W:0]    wdog;

  logic [NUM_CH-1:0] ch_carry_c;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_commit_c;
  logic              xfer_c;
  logic              commit_c;
  logic              tgt_carry_c;
  logic              tgt_en_c;
  logic              wdog_done_c;

  // Commit at the target's period boundary, immediately if it is idle,
  // on sync, or once the watchdog proves no carry is coming.
  always_comb begin
    xfer_c      = cfg_valid & cfg_ready;
    tgt_carry_c = ch_carry_c[pend_ch];
    tgt_en_c    = ch_en[pend_ch];
    wdog_done_c = (wdog == WDOG_LAST);
    commit_c    = pend_valid & (sync_i | ~tgt_en_c | tgt_carry_c | wdog_done_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_inc   <= '0;
      pend_mode  <= MODE_STROBE;
      pend_en    <= 1'b0;
      wdog       <= '0;
      cfg_ready  <= 1'b1;
      busy_o     <= 1'b0;
    end else if (commit_c) begin
      pend_valid <= 1'b0;
      wdog       <= '0;
      cfg_ready  <= 1'b1;
      busy_o     <= 1'b0;
    end else if (xfer_c) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg_ch;
      pend_inc   <= cfg_inc;
      pend_mode  <= cfg_mode;
      pend_en    <= cfg_en;
      wdog       <= '0;
      cfg_ready  <= 1'b0;
      busy_o     <= 1'b1;
    end else if (pend_valid) begin
      wdog <= wdog + (ACC_W+1)'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_commit_c[c] = commit_c & (pend_ch == CH_W'(c));

    frac_acc_ch #(
      .ACC_W   (ACC_W),
      .RST_INC (RST_INC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sync_i      (sync_i),
      .commit      (ch_commit_c[c]),
      .commit_inc  (pend_inc),
      .commit_mode (pend_mode),
      .commit_en   (pend_en),
      .carry_c     (ch_carry_c[c]),
      .en          (ch_en[c]),
      .ce          (ce_o[c]),
      .tgl         (tgl_o[c])
    );
  end

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Directed self-checking bench for frac_clk_en_gen (4 channels, 16-bit accumulators).
module tb_frac_clk_en_gen;
  import clk_gen_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CH_W   = 2;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              cfg_mode;
  logic              cfg_en;
  logic              sync_i;
  logic [NUM_CH-1:0] ce_o;
  logic [NUM_CH-1:0] tgl_o;
  logic              busy_o;

  int n_checks;
  int n_pass;

  frac_clk_en_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .CH_W    (CH_W),
    .RST_INC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_mode  (cfg_mode),
    .cfg_en    (cfg_en),
    .sync_i    (sync_i),
    .ce_o      (ce_o),
    .tgl_o     (tgl_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cfg_ready, then presents one request for one edge.
  task automatic cfg_write(input int ch, input logic [15:0] inc, input logic mode,
                           input logic en, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (cfg_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (cfg_ready !== 1'b1) timeout = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_inc   = inc;
    cfg_mode  = mode;
    cfg_en    = en;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit timeout);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    timeout = (busy_o !== 1'b0);
  endtask

  task automatic test_reset();
    int ce_seen;
    logic [31:0] inc9;
    ce_seen = 0;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cfg_ready);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o);
    else n_pass++;
    n_checks++;
    if (ce_o !== 4'b0000) $display("FAIL reset_ce: got %b expected 0000", ce_o);
    else n_pass++;
    n_checks++;
    if (tgl_o !== 4'b0000) $display("FAIL reset_tgl: got %b expected 0000", tgl_o);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ce_o !== 4'b0000) ce_seen++;
    end
    n_checks++;
    if (ce_seen !== 0) $display("FAIL reset_idle_ce: got %0d pulses expected 0", ce_seen);
    else n_pass++;
    inc9 = inc_for(64'd9_000_000, 64'd50_000_000, ACC_W);
    n_checks++;
    if (inc9 !== 32'h0000_2E14) $display("FAIL inc_for_9mhz: got %h expected 00002e14", inc9);
    else n_pass++;
  endtask

  task automatic test_basic_rates();
    bit to;
    int ce_seen;
    logic exp_ce;
    cfg_write(0, 16'h8000, MODE_STROBE, 1'b1, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL basic_cfg_timeout: got %b expected 0", to);
    else n_pass++;
    n_checks++;
    if ({busy_o, cfg_ready} !== 2'b10) $display("FAIL basic_pending: got busy/ready %b expected 10", {busy_o, cfg_ready});
    else n_pass++;
    tick();
    n_checks++;
    if ({busy_o, cfg_ready} !== 2'b01) $display("FAIL basic_commit: got busy/ready %b expected 01", {busy_o, cfg_ready});
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_ce = (k % 2 == 0);
      n_checks++;
      if (ce_o !== {3'b000, exp_ce}) $display("FAIL basic_8000_ce k=%0d: got %b expected %b", k, ce_o, {3'b000, exp_ce});
      else n_pass++;
    end
    // Disable ch0 and confirm it goes quiet.
    cfg_write(0, 16'h0000, MODE_STROBE, 1'b0, to);
    wait_idle(to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL basic_disable_timeout: got %b expected 0", to);
    else n_pass++;
    tick();
    tick();
    ce_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ce_o !== 4'b0000) ce_seen++;
    end
    n_checks++;
    if (ce_seen !== 0) $display("FAIL basic_disabled_ce: got %0d pulses expected 0", ce_seen);
    else n_pass++;
    cfg_write(0, 16'h4000, MODE_STROBE, 1'b1, to);
    tick();
    n_checks++;
    if ({busy_o, ce_o} !== 5'b00000) $display("FAIL basic_4000_commit: got busy/ce %b expected 00000", {busy_o, ce_o});
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ce = (k % 4 == 0);
      n_checks++;
      if (ce_o !== {3'b000, exp_ce}) $display("FAIL basic_4000_ce k=%0d: got %b expected %b", k, ce_o, {3'b000, exp_ce});
      else n_pass++;
    end
  endtask

  task automatic test_reprogram();
    bit to;
    logic [7:0] exp_ce;
    logic [7:0] exp_busy;
    exp_ce   = 8'b1010_1000;
    exp_busy = 8'b0000_0111;
    cfg_write(0, 16'h8000, MODE_STROBE, 1'b1, to);
    for (int r = 0; r < 8; r++) begin
      if (r > 0) tick();
      n_checks++;
      if (ce_o[0] !== exp_ce[r]) $display("FAIL reprog_ce r=%0d: got %b expected %b", r, ce_o[0], exp_ce[r]);
      else n_pass++;
      n_checks++;
      if ({busy_o, cfg_ready} !== {exp_busy[r], ~exp_busy[r]})
        $display("FAIL reprog_handshake r=%0d: got busy/ready %b expected %b", r, {busy_o, cfg_ready}, {exp_busy[r], ~exp_busy[r]});
      else n_pass++;
    end
  endtask

  task automatic test_sync();
    bit to;
    int n;
    logic [3:0] exp_ce [1:4];
    logic [3:0] exp_tgl [1:4];
    exp_ce[1] = 4'b0000; exp_tgl[1] = 4'b0000;
    exp_ce[2] = 4'b0001; exp_tgl[2] = 4'b0001;
    exp_ce[3] = 4'b0000; exp_tgl[3] = 4'b0001;
    exp_ce[4] = 4'b0011; exp_tgl[4] = 4'b0010;
    cfg_write(0, 16'h8000, MODE_TGL, 1'b1, to);
    wait_idle(to);
    cfg_write(1, 16'h4000, MODE_TGL, 1'b1, to);
    wait_idle(to);
    n = 0;
    while (tgl_o[1:0] !== 2'b11 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (tgl_o[1:0] !== 2'b11) $display("FAIL sync_presync_tgl: got %b expected 11", tgl_o[1:0]);
    else n_pass++;
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    n_checks++;
    if ({ce_o, tgl_o} !== 8'h00) $display("FAIL sync_clear: got ce/tgl %b expected 00000000", {ce_o, tgl_o});
    else n_pass++;
    for (int s = 1; s <= 4; s++) begin
      tick();
      n_checks++;
      if ({ce_o, tgl_o} !== {exp_ce[s], exp_tgl[s]})
        $display("FAIL sync_after s=%0d: got ce/tgl %b expected %b", s, {ce_o, tgl_o}, {exp_ce[s], exp_tgl[s]});
      else n_pass++;
    end
    // A pending request is committed by sync at once.
    cfg_write(1, 16'h8000, MODE_TGL, 1'b1, to);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    n_checks++;
    if ({busy_o, cfg_ready, ce_o, tgl_o} !== 10'b01_0000_0000)
      $display("FAIL sync_commit: got busy/ready/ce/tgl %b expected 0100000000", {busy_o, cfg_ready, ce_o, tgl_o});
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({ce_o, tgl_o} !== 8'b0011_0011) $display("FAIL sync_commit_rate: got ce/tgl %b expected 00110011", {ce_o, tgl_o});
    else n_pass++;
  endtask

  // Fractional rate on ch1 measured while ch2 sits in the stall watchdog.
  task automatic test_frac_and_stall();
    bit to;
    int busy_drop;
    int ce_cnt;
    int rise_cnt;
    logic prev_tgl;
    logic exp_ce;
    cfg_write(2, 16'h0000, MODE_STROBE, 1'b1, to);
    wait_idle(to);
    cfg_write(1, 16'(inc_for(64'd9_000_000, 64'd50_000_000, ACC_W)), MODE_TGL, 1'b1, to);
    wait_idle(to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL frac_cfg_timeout: got %b expected 0", to);
    else n_pass++;
    cfg_write(2, 16'h1000, MODE_STROBE, 1'b1, to);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL stall_capture_busy: got %b expected 1", busy_o);
    else n_pass++;
    busy_drop = 0;
    ce_cnt    = 0;
    rise_cnt  = 0;
    prev_tgl  = tgl_o[1];
    for (int r = 1; r <= 65536; r++) begin
      tick();
      if (r < 65536 && busy_o !== 1'b1) busy_drop++;
      if (ce_o[1] === 1'b1) ce_cnt++;
      if (tgl_o[1] === 1'b1 && prev_tgl === 1'b0) rise_cnt++;
      prev_tgl = tgl_o[1];
    end
    n_checks++;
    if (busy_drop !== 0) $display("FAIL stall_busy_held: got %0d early drops expected 0", busy_drop);
    else n_pass++;
    n_checks++;
    if ({busy_o, cfg_ready} !== 2'b01) $display("FAIL stall_commit: got busy/ready %b expected 01", {busy_o, cfg_ready});
    else n_pass++;
    n_checks++;
    if (ce_cnt !== 11796) $display("FAIL frac_ce_count: got %0d expected 11796", ce_cnt);
    else n_pass++;
    n_checks++;
    if (rise_cnt !== 5898) $display("FAIL frac_tgl_rises: got %0d expected 5898", rise_cnt);
    else n_pass++;
    for (int s = 1; s <= 48; s++) begin
      tick();
      exp_ce = (s % 16 == 0);
      n_checks++;
      if (ce_o[2] !== exp_ce) $display("FAIL stall_rate s=%0d: got %b expected %b", s, ce_o[2], exp_ce);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pending();
    bit to;
    int ce_seen;
    int tgl_seen;
    int busy_seen;
    cfg_write(2, 16'h0010, MODE_TGL, 1'b1, to);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL rstpend_pending: got busy %b expected 1", busy_o);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy_o, cfg_ready, ce_o, tgl_o} !== 10'b01_0000_0000)
      $display("FAIL rstpend_state: got busy/ready/ce/tgl %b expected 0100000000", {busy_o, cfg_ready, ce_o, tgl_o});
    else n_pass++;
    rst = 1'b0;
    ce_seen   = 0;
    tgl_seen  = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ce_o !== 4'b0000) ce_seen++;
      if (tgl_o !== 4'b0000) tgl_seen++;
      if (busy_o !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (ce_seen !== 0) $display("FAIL rstpend_ce: got %0d active cycles expected 0", ce_seen);
    else n_pass++;
    n_checks++;
    if (tgl_seen !== 0) $display("FAIL rstpend_tgl: got %0d active cycles expected 0", tgl_seen);
    else n_pass++;
    n_checks++;
    if (busy_seen !== 0) $display("FAIL rstpend_busy: got %0d busy cycles expected 0", busy_seen);
    else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_inc   = '0;
    cfg_mode  = 1'b0;
    cfg_en    = 1'b0;
    sync_i    = 1'b0;
    test_reset();
    test_basic_rates();
    test_reprogram();
    test_sync();
    test_frac_and_stall();
    test_reset_mid_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
